wb_rr_intercon: RTL

WB_RR_INTERCON -- requirements
Module: wb_rr_intercon

---
 rtl/wb_rr_intercon.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/wb_rr_intercon.sv
// Round-robin Wishbone shared-bus interconnect: NUM_M masters onto NUM_S prefix-decoded slaves.
// Optional bus watchdog is compiled in when WB_RR_INTERCON_TIMEOUT_EN is defined.
module wb_rr_intercon #(
  parameter int unsigned                 NUM_M    = 2,
  parameter int unsigned                 NUM_S    = 6,
  parameter int unsigned                 S_ADDR_W = 3,
  parameter logic [NUM_S*S_ADDR_W-1:0]   S_ADDR   = {3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b000},
  parameter int unsigned                 TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_M*32-1:0]   m_adr_i,
  input  logic [NUM_M*32-1:0]   m_dat_i,
  input  logic [NUM_M*4-1:0]    m_sel_i,
  input  logic [NUM_M-1:0]      m_we_i,
  input  logic [NUM_M-1:0]      m_cyc_i,
  input  logic [NUM_M-1:0]      m_stb_i,
  output logic [NUM_M*32-1:0]   m_dat_o,
  output logic [NUM_M-1:0]      m_ack_o,
  output logic [NUM_M-1:0]      m_err_o,
  output logic [31:0]           s_adr_o,
  output logic [31:0]           s_dat_o,
  output logic [3:0]            s_sel_o,
  output logic                  s_we_o,
  output logic [NUM_S-1:0]      s_cyc_o,
  output logic [NUM_S-1:0]      s_stb_o,
  input  logic [NUM_S*32-1:0]   s_dat_i,
  input  logic [NUM_S-1:0]      s_ack_i
);

  localparam int unsigned GW   = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int unsigned SW   = (NUM_S > 1) ? $clog2(NUM_S) : 1;
  localparam int unsigned WD_W = 16;

  // Elaboration-time parameter sanity checks
  if (NUM_M < 1 || NUM_M > 4) begin : g_bad_num_m
    $error("wb_rr_intercon: NUM_M must be 1..4");
  end
  if (NUM_S < 1 || NUM_S > 8) begin : g_bad_num_s
    $error("wb_rr_intercon: NUM_S must be 1..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("wb_rr_intercon: TIMEOUT must be 1..65535");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [GW-1:0]   last_q, last_d;
  logic [GW-1:0]   rr_pick;
  logic            err_q;
  logic            to_fire;

  logic [31:0]     g_adr, g_dat;
  logic [3:0]      g_sel;
  logic            g_we, g_cyc, g_stb;
  logic            hit;
  logic [SW-1:0]   sel_idx;
  logic            slv_ack;
  logic [31:0]     slv_dat;

  // Granted master's request signals
  always_comb begin
    g_adr = m_adr_i[32*int'(gnt_q) +: 32];
    g_dat = m_dat_i[32*int'(gnt_q) +: 32];
    g_sel = m_sel_i[4*int'(gnt_q) +: 4];
    g_we  = m_we_i[gnt_q];
    g_cyc = m_cyc_i[gnt_q];
    g_stb = m_stb_i[gnt_q];
  end

  // Prefix decode; scanning downward lets the lowest matching slave win
  always_comb begin
    hit     = 1'b0;
    sel_idx = '0;
    for (int k = int'(NUM_S) - 1; k >= 0; k--) begin
      if (g_adr[31 -: S_ADDR_W] == S_ADDR[k*S_ADDR_W +: S_ADDR_W]) begin
        hit     = 1'b1;
        sel_idx = SW'(k);
      end
    end
  end

  assign slv_ack = s_ack_i[sel_idx];
  assign slv_dat = s_dat_i[32*int'(sel_idx) +: 32];

  // Round-robin pick: first requester after last_q in circular order
  always_comb begin
    logic found;
    found   = 1'b0;
    rr_pick = last_q;
    for (int i = 1; i <= int'(NUM_M); i++) begin
      int idx;
      idx = (int'(last_q) + i) % int'(NUM_M);
      if (!found && m_cyc_i[idx]) begin
        found   = 1'b1;
        rr_pick = GW'(idx);
      end
    end
  end

`ifdef WB_RR_INTERCON_TIMEOUT_EN
  logic [WD_W-1:0] wd_q, wd_d;

  assign to_fire = (state_q == OWNED) && (wd_q == WD_W'(TIMEOUT));

  // Counts strobed, un-acked cycles of the current owner; an ack in the
  // cycle the count would reach the limit clears it, so the ack wins
  always_comb begin
    wd_d = '0;
    if (state_q == OWNED && !to_fire && g_cyc && g_stb && !(hit && slv_ack))
      wd_d = wd_q + WD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`else
  assign to_fire = 1'b0;
`endif

  // Arbiter state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= GW'(NUM_M - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // Arbiter next state; release always passes through IDLE before a re-grant
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|m_cyc_i) begin
          state_d = OWNED;
          gnt_d   = rr_pick;
        end
      end
      OWNED: begin
        if (to_fire || !g_cyc) begin
          state_d = IDLE;
          last_d  = gnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Unmapped-address error, one cycle after the strobe is sampled
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= (state_q == OWNED) && g_cyc && g_stb && !hit && !err_q;
  end

  // Bus routing; everything is held at zero while rst is high
  always_comb begin
    m_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = '0;
    s_stb_o = '0;
    if (!rst) begin
      if (err_q) m_err_o[gnt_q] = 1'b1;
      if (state_q == OWNED) begin
        s_adr_o = g_adr;
        s_dat_o = g_dat;
        s_sel_o = g_sel;
        s_we_o  = g_we;
        if (to_fire) begin
          m_err_o[gnt_q] = 1'b1;
        end else if (g_cyc && hit) begin
          s_cyc_o[sel_idx]               = 1'b1;
          s_stb_o[sel_idx]               = g_stb;
          m_dat_o[32*int'(gnt_q) +: 32]  = slv_dat;
          m_ack_o[gnt_q]                 = g_stb && slv_ack;
        end
      end
    end
  end

endmodule
